// File: rtl/gpu_pkg.sv
// Shared constants for the draw engine: register map, opcodes, STATUS bits
// and the engine state encoding.
package gpu_pkg;

  localparam logic [2:0] REG_COLOR      = 3'd0;
  localparam logic [2:0] REG_X0         = 3'd1;
  localparam logic [2:0] REG_Y0         = 3'd2;
  localparam logic [2:0] REG_X1         = 3'd3;
  localparam logic [2:0] REG_Y1         = 3'd4;
  localparam logic [2:0] REG_CMD        = 3'd5;
  localparam logic [2:0] REG_STATUS     = 3'd6;
  localparam logic [2:0] REG_FIFO_COUNT = 3'd7;

  localparam logic [7:0] OP_PLOT     = 8'h00;
  localparam logic [7:0] OP_FILL     = 8'h01;
  localparam logic [7:0] OP_CLEAR    = 8'h02;
  localparam logic [7:0] OP_CLRFLAGS = 8'hFF;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_BADOP_BIT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2
  } eng_state_e;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Command FIFO: power-of-two depth, show-ahead read port. A push while full
// is dropped even if a pop happens in the same cycle.
module gpu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/gpu_draw_engine.sv
// CPU-programmable rectangle engine: register file, command FIFO and a
// clipping pixel walker that streams row-major pixels to a framebuffer.
module gpu_draw_engine
  import gpu_pkg::*;
#(
  parameter int X_W        = 8,
  parameter int Y_W        = 8,
  parameter int COLOR_W    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119
) (
  input  logic               SYS_CLOCK,
  input  logic               RESETB,
  input  logic [2:0]         RS,
  input  logic [7:0]         DATA_IN,
  output logic [7:0]         DATA_OUT,
  input  logic               CE,
  input  logic               RWB,
  input  logic               BUS_STB,
  output logic [X_W-1:0]     FB_X,
  output logic [Y_W-1:0]     FB_Y,
  output logic [COLOR_W-1:0] FB_COLOR,
  output logic               FB_WE,
  input  logic               FB_READY,
  output logic               BUSY
);

  localparam int ENTRY_W = 8 + COLOR_W + 2*X_W + 2*Y_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W:0] XLIM = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0] YLIM = (Y_W+1)'(Y_MAX);

  logic [COLOR_W-1:0] color_q;
  logic [X_W-1:0]     x0_q, x1_q;
  logic [Y_W-1:0]     y0_q, y1_q;
  logic               ovf_q, bad_q;
  logic [7:0]         dout_q;

  logic access, wr_en, rd_en, cmd_wr, clr_flags, push, pop, bad_set;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [7:0]         status, rd_data;

  eng_state_e         state_q;
  logic [ENTRY_W-1:0] entry_q;
  logic [X_W:0]       x_q, xs_q, xe_q;
  logic [Y_W:0]       y_q, ye_q;
  logic               fb_we_q;
  logic [COLOR_W-1:0] fb_col_q;

  assign access    = BUS_STB && !CE;
  assign wr_en     = access && !RWB;
  assign rd_en     = access && RWB;
  assign cmd_wr    = wr_en && (RS == REG_CMD);
  assign clr_flags = cmd_wr && (DATA_IN == OP_CLRFLAGS);
  assign push      = cmd_wr && !clr_flags;
  assign fifo_din  = {DATA_IN, color_q, x0_q, y0_q, x1_q, y1_q};
  assign pop       = (state_q == S_IDLE) && !fifo_empty;
  assign BUSY      = (state_q != S_IDLE) || !fifo_empty;

  gpu_cmd_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (SYS_CLOCK),
    .rst_ni  (RESETB),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status               = '0;
    status[ST_BUSY_BIT]  = BUSY;
    status[ST_FULL_BIT]  = fifo_full;
    status[ST_EMPTY_BIT] = fifo_empty;
    status[ST_OVF_BIT]   = ovf_q;
    status[ST_BADOP_BIT] = bad_q;
  end

  always_comb begin
    rd_data = '0;
    case (RS)
      REG_COLOR:      rd_data[COLOR_W-1:0] = color_q;
      REG_X0:         rd_data[X_W-1:0]     = x0_q;
      REG_Y0:         rd_data[Y_W-1:0]     = y0_q;
      REG_X1:         rd_data[X_W-1:0]     = x1_q;
      REG_Y1:         rd_data[Y_W-1:0]     = y1_q;
      REG_STATUS:     rd_data              = status;
      REG_FIFO_COUNT: rd_data[CNT_W-1:0]   = fifo_count;
      default:        rd_data              = '0;
    endcase
  end

  always_ff @(posedge SYS_CLOCK or negedge RESETB) begin
    if (!RESETB) begin
      color_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (wr_en) begin
        case (RS)
          REG_COLOR: color_q <= DATA_IN[COLOR_W-1:0];
          REG_X0:    x0_q    <= DATA_IN[X_W-1:0];
          REG_Y0:    y0_q    <= DATA_IN[Y_W-1:0];
          REG_X1:    x1_q    <= DATA_IN[X_W-1:0];
          REG_Y1:    y1_q    <= DATA_IN[Y_W-1:0];
          default:   ;
        endcase
      end
      if (push && fifo_full) ovf_q <= 1'b1;
      else if (clr_flags)    ovf_q <= 1'b0;
      // A bad opcode retiring in the same cycle as a clear is not lost.
      if (bad_set)        bad_q <= 1'b1;
      else if (clr_flags) bad_q <= 1'b0;
      if (rd_en) dout_q <= rd_data;
    end
  end

  assign DATA_OUT = dout_q;

  logic [7:0]         e_op;
  logic [COLOR_W-1:0] e_color;
  logic [X_W-1:0]     e_x0, e_x1;
  logic [Y_W-1:0]     e_y0, e_y1;

  assign e_y1    = entry_q[Y_W-1:0];
  assign e_x1    = entry_q[Y_W +: X_W];
  assign e_y0    = entry_q[Y_W+X_W +: Y_W];
  assign e_x0    = entry_q[2*Y_W+X_W +: X_W];
  assign e_color = entry_q[2*Y_W+2*X_W +: COLOR_W];
  assign e_op    = entry_q[ENTRY_W-1 -: 8];

  logic [X_W:0] cx_s, cx_e;
  logic [Y_W:0] cy_s, cy_e;
  logic         op_ok, region_ok;

  // Bounds are one bit wider than the coordinates so a clamp to 2^W-1 is safe.
  always_comb begin
    cx_s  = {1'b0, e_x0};
    cx_e  = {1'b0, e_x0};
    cy_s  = {1'b0, e_y0};
    cy_e  = {1'b0, e_y0};
    op_ok = 1'b1;
    case (e_op)
      OP_PLOT: ;
      OP_FILL: begin
        cx_e = ({1'b0, e_x1} > XLIM) ? XLIM : {1'b0, e_x1};
        cy_e = ({1'b0, e_y1} > YLIM) ? YLIM : {1'b0, e_y1};
      end
      OP_CLEAR: begin
        cx_s = '0;
        cx_e = XLIM;
        cy_s = '0;
        cy_e = YLIM;
      end
      default: op_ok = 1'b0;
    endcase
    region_ok = op_ok && (cx_s <= cx_e) && (cy_s <= cy_e) &&
                (cx_s <= XLIM) && (cy_s <= YLIM);
  end

  assign bad_set = (state_q == S_LOAD) && !op_ok;

  always_ff @(posedge SYS_CLOCK or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= S_IDLE;
      entry_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xs_q     <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      fb_we_q  <= 1'b0;
      fb_col_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            entry_q <= fifo_dout;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (region_ok) begin
            x_q      <= cx_s;
            y_q      <= cy_s;
            xs_q     <= cx_s;
            xe_q     <= cx_e;
            ye_q     <= cy_e;
            fb_col_q <= e_color;
            fb_we_q  <= 1'b1;
            state_q  <= S_DRAW;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_DRAW: begin
          if (FB_READY) begin
            if (x_q == xe_q) begin
              if (y_q == ye_q) begin
                fb_we_q <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                x_q <= xs_q;
                y_q <= y_q + (Y_W+1)'(1);
              end
            end else begin
              x_q <= x_q + (X_W+1)'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign FB_X     = x_q[X_W-1:0];
  assign FB_Y     = y_q[Y_W-1:0];
  assign FB_COLOR = fb_col_q;
  assign FB_WE    = fb_we_q;

endmodule

// File: tb/tb_gpu_draw_engine.sv
// Directed plus randomized bench for gpu_draw_engine against a pixel-list
// model of the drawing rules.
module tb_gpu_draw_engine;

  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  logic       SYS_CLOCK = 1'b0;
  logic       RESETB    = 1'b1;
  logic [2:0] RS        = '0;
  logic [7:0] DATA_IN   = '0;
  logic [7:0] DATA_OUT;
  logic       CE        = 1'b1;
  logic       RWB       = 1'b1;
  logic       BUS_STB   = 1'b0;
  logic [7:0] FB_X;
  logic [7:0] FB_Y;
  logic [2:0] FB_COLOR;
  logic       FB_WE;
  logic       FB_READY  = 1'b1;
  logic       BUSY;

  gpu_draw_engine dut (
    .SYS_CLOCK (SYS_CLOCK),
    .RESETB    (RESETB),
    .RS        (RS),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .CE        (CE),
    .RWB       (RWB),
    .BUS_STB   (BUS_STB),
    .FB_X      (FB_X),
    .FB_Y      (FB_Y),
    .FB_COLOR  (FB_COLOR),
    .FB_WE     (FB_WE),
    .FB_READY  (FB_READY),
    .BUSY      (BUSY)
  );

  // ---- clock / reset ----
  always #5 SYS_CLOCK = ~SYS_CLOCK;

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;   // 0 high, 1 toggle, 2 random, 3 low
  bit model_bad = 0;
  logic [18:0] exp_q[$];
  logic [18:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [18:0] pix(input int x, input int y, input int c);
    return {8'(x), 8'(y), 3'(c)};
  endfunction

  // ---- framebuffer side: ready driver and transfer monitor ----
  initial begin
    forever begin
      @(posedge SYS_CLOCK);
      #1;
      case (ready_mode)
        0:       FB_READY = 1'b1;
        1:       FB_READY = ~FB_READY;
        2:       FB_READY = 1'($urandom_range(0, 1));
        default: FB_READY = 1'b0;
      endcase
    end
  end

  logic        stall_prev = 1'b0;
  logic [19:0] held = '0;
  always @(negedge SYS_CLOCK) begin
    if (RESETB && stall_prev) check("stall_hold", {12'b0, FB_WE, FB_X, FB_Y, FB_COLOR}, {12'b0, held});
    if (RESETB && FB_WE && FB_READY) got_q.push_back({FB_X, FB_Y, FB_COLOR});
    stall_prev = RESETB && FB_WE && !FB_READY;
    held = {FB_WE, FB_X, FB_Y, FB_COLOR};
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---- driver tasks ----
  task automatic bus_op(input logic ce_n, input logic rwb, input logic [2:0] rs,
                        input logic [7:0] d, output logic [7:0] q);
    @(negedge SYS_CLOCK);
    CE = ce_n; RWB = rwb; RS = rs; DATA_IN = d; BUS_STB = 1'b1;
    @(posedge SYS_CLOCK);
    #1;
    q = DATA_OUT;
    BUS_STB = 1'b0; CE = 1'b1;
  endtask

  task automatic wr(input logic [2:0] rs, input int d);
    logic [7:0] dummy;
    bus_op(1'b0, 1'b0, rs, 8'(d), dummy);
  endtask

  task automatic rd_check(input string tag, input logic [2:0] rs, input logic [7:0] exp_v);
    logic [7:0] q;
    bus_op(1'b0, 1'b1, rs, 8'h00, q);
    check(tag, {24'b0, q}, {24'b0, exp_v});
  endtask

  // ---- reference model: pixel list straight from the drawing rules ----
  task automatic model_cmd(input int op, input int col, input int x0, input int y0,
                           input int x1, input int y1);
    int xe, ye;
    case (op)
      0: if (x0 <= X_MAX && y0 <= Y_MAX) exp_q.push_back(pix(x0, y0, col));
      1: begin
        xe = (x1 > X_MAX) ? X_MAX : x1;
        ye = (y1 > Y_MAX) ? Y_MAX : y1;
        for (int y = y0; y <= ye; y++)
          for (int x = x0; x <= xe; x++) exp_q.push_back(pix(x, y, col));
      end
      2: begin
        for (int y = 0; y <= Y_MAX; y++)
          for (int x = 0; x <= X_MAX; x++) exp_q.push_back(pix(x, y, col));
      end
      default: model_bad = 1;
    endcase
  endtask

  task automatic send_cmd(input int op, input int col, input int x0, input int y0,
                          input int x1, input int y1);
    wr(3'd0, col); wr(3'd1, x0); wr(3'd2, y0); wr(3'd3, x1); wr(3'd4, y1);
    model_cmd(op, col, x0, y0, x1, y1);
    wr(3'd5, op);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (BUSY !== 1'b0 && n < budget) begin
      @(posedge SYS_CLOCK);
      #1;
      n++;
    end
    check(tag, {31'b0, BUSY}, 32'd0);
  endtask

  task automatic compare_pixels(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check(tag, {13'b0, got_q[i]}, {13'b0, exp_q[i]});
      if (got_q[i] !== exp_q[i]) break;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---- directed and random sequence ----
  initial begin
    bit seen;
    int n, op, col, x0, y0, x1, y1;

    #1 RESETB = 1'b0;
    repeat (3) @(posedge SYS_CLOCK);
    #1;
    check("rst_dout", {24'b0, DATA_OUT}, 32'h0);
    check("rst_we", {31'b0, FB_WE}, 32'h0);
    check("rst_busy", {31'b0, BUSY}, 32'h0);
    check("rst_xy", {16'b0, FB_X, FB_Y}, 32'h0);
    #1 RESETB = 1'b1;

    rd_check("status_reset", 3'd6, 8'h04);
    rd_check("count_reset", 3'd7, 8'h00);
    wr(3'd0, 8'hFD);
    rd_check("color_lowbits", 3'd0, 8'h05);
    wr(3'd1, 8'hAB);
    rd_check("x0_rw", 3'd1, 8'hAB);
    wr(3'd4, 8'h5A);
    rd_check("y1_rw", 3'd4, 8'h5A);
    begin
      logic [7:0] q;
      bus_op(1'b1, 1'b0, 3'd1, 8'h11, q);
    end
    rd_check("ce_ignored", 3'd1, 8'hAB);
    wr(3'd6, 8'hFF);
    wr(3'd7, 8'hFF);
    rd_check("status_ro", 3'd6, 8'h04);
    rd_check("cmd_reads0", 3'd5, 8'h00);

    // PLOT with latency bound
    ready_mode = 0;
    wr(3'd0, 5); wr(3'd1, 3); wr(3'd2, 4);
    model_cmd(0, 5, 3, 4, 0, 0);
    wr(3'd5, 0);
    seen = 0;
    repeat (3) begin
      if (!seen) begin
        @(posedge SYS_CLOCK);
        #1;
        if (FB_WE) seen = 1;
      end
    end
    check("plot_latency", {31'b0, seen}, 32'd1);
    wait_idle("plot_idle", 50);
    compare_pixels("plot_pix");

    // FILL with stalling framebuffer
    ready_mode = 1;
    send_cmd(1, 6, 2, 1, 4, 2);
    wait_idle("fill_idle", 100);
    compare_pixels("fill_pix");

    // Overflow: engine stalled on one PLOT, then five CMD writes
    ready_mode = 3;
    repeat (2) @(posedge SYS_CLOCK);
    send_cmd(0, 7, 10, 10, 0, 0);
    repeat (3) @(posedge SYS_CLOCK);
    for (int i = 0; i < 5; i++) begin
      wr(3'd1, 20 + i);
      if (i < 4) model_cmd(0, 7, 20 + i, 10, 0, 0);
      wr(3'd5, 0);
    end
    rd_check("ovf_status", 3'd6, 8'h0B);
    rd_check("ovf_count", 3'd7, 8'h04);
    wr(3'd5, 8'hFF);
    rd_check("ovf_cleared", 3'd6, 8'h03);
    ready_mode = 0;
    wait_idle("ovf_idle", 200);
    compare_pixels("ovf_pix");

    // Clipping and bad opcode
    send_cmd(1, 3, 158, 119, 200, 119);
    wait_idle("clip_idle", 100);
    compare_pixels("clip_pix");
    send_cmd(1, 2, 10, 0, 5, 3);
    wait_idle("inv_idle", 100);
    compare_pixels("inv_pix");
    send_cmd(7, 1, 1, 1, 2, 2);
    wait_idle("bad_idle", 100);
    compare_pixels("bad_pix");
    rd_check("bad_status", 3'd6, 8'h14);
    wr(3'd5, 8'hFF);
    model_bad = 0;
    rd_check("bad_cleared", 3'd6, 8'h04);

    // Randomized commands, three queued back to back per batch
    ready_mode = 2;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        n = $urandom_range(0, 9);
        op = (n < 3) ? 0 : (n < 9) ? 1 : $urandom_range(3, 254);
        col = $urandom_range(0, 7);
        x0 = $urandom_range(0, 165);
        y0 = $urandom_range(0, 125);
        x1 = x0 + $urandom_range(0, 6) - 1;
        y1 = y0 + $urandom_range(0, 6) - 1;
        if (x1 < 0) x1 = 0;
        if (y1 < 0) y1 = 0;
        send_cmd(op, col, x0, y0, x1, y1);
      end
      wait_idle("rand_idle", 5000);
      compare_pixels("rand_pix");
    end
    rd_check("rand_status", 3'd6, model_bad ? 8'h14 : 8'h04);
    wr(3'd5, 8'hFF);
    model_bad = 0;

    // Full-screen CLEAR
    ready_mode = 0;
    send_cmd(2, 4, 0, 0, 0, 0);
    wait_idle("clear_idle", 25000);
    compare_pixels("clear_pix");

    // Reset in the middle of a 10x10 FILL
    send_cmd(1, 1, 0, 0, 9, 9);
    n = 0;
    while (got_q.size() < 3 && n < 50) begin
      @(posedge SYS_CLOCK);
      #1;
      n++;
    end
    check("mid_reach3", got_q.size(), 32'd3);
    #1 RESETB = 1'b0;
    #1;
    check("mid_we", {31'b0, FB_WE}, 32'h0);
    check("mid_busy", {31'b0, BUSY}, 32'h0);
    check("mid_xyc", {13'b0, FB_X, FB_Y, FB_COLOR}, 32'h0);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    @(posedge SYS_CLOCK);
    #2 RESETB = 1'b1;
    repeat (30) @(posedge SYS_CLOCK);
    #1;
    compare_pixels("mid_pix");
    rd_check("mid_status", 3'd6, 8'h04);
    rd_check("mid_x1", 3'd3, 8'h00);

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpu_draw_engine.md
GPU_DRAW_ENGINE -- requirements
Module: gpu_draw_engine

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- X_W, 8, x coordinate width.
- Y_W, 8, y coordinate width.
- COLOR_W, 3, color width.
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).
- X_MAX, 159, last visible column.
- Y_MAX, 119, last visible row.

REQ-002 Ports SHALL be as follows, one per line:
- SYS_CLOCK  in  1  single clock, all logic on its rising edge.
- RESETB  in  1  asynchronous active-low reset.
- RS  in  3  register select.
- DATA_IN  in  8  CPU write data.
- DATA_OUT  out  8  CPU read data, registered.
- CE  in  1  chip enable, active-low.
- RWB  in  1  1=read, 0=write.
- BUS_STB  in  1  one-cycle qualifier for a synchronised CPU access.
- FB_X  out  X_W  pixel x.
- FB_Y  out  Y_W  pixel y.
- FB_COLOR  out  COLOR_W  pixel color.
- FB_WE  out  1  pixel valid.
- FB_READY  in  1  framebuffer accepts pixel.
- BUSY  out  1  engine drawing or FIFO non-empty.

Function
REQ-003 An access SHALL occur only in a cycle with BUS_STB=1 and CE=0; all other cycles SHALL be ignored.
REQ-004 The register map SHALL be: 0 COLOR, 1 X0, 2 Y0, 3 X1, 4 Y1 (all read/write), 5 CMD (write only), 6 STATUS, 7 FIFO_COUNT (read only).
- Writes to registers wider than their field SHALL take the low bits.
- Writes to 6 and 7 SHALL be ignored.
REQ-005 A read SHALL update DATA_OUT on the clock edge of the access cycle, with zero-extended fields; CMD SHALL read 0x00.
REQ-006 STATUS SHALL be bit0 BUSY, bit1 FIFO full, bit2 FIFO empty, bit3 OVERFLOW (sticky), bit4 BAD_OP (sticky), bits7:5 zero.
REQ-007 A CMD write SHALL push {opcode, COLOR, X0, Y0, X1, Y1} into the FIFO if the FIFO is not full at that cycle; otherwise the push SHALL be dropped and OVERFLOW set.
REQ-008 Opcodes SHALL be:
- 0x00 PLOT: one pixel at (X0,Y0).
- 0x01 FILL: rectangle X0..X1 by Y0..Y1.
- 0x02 CLEAR: 0..X_MAX by 0..Y_MAX in COLOR.
- 0xFF CLRFLAGS: clears OVERFLOW and BAD_OP immediately, is not pushed, and costs no FIFO slot.
REQ-009 Other opcodes SHALL be pushed, then discarded at pop with BAD_OP set and no pixels emitted.
REQ-010 Engine FSM states SHALL be IDLE, LOAD, DRAW.
- IDLE to LOAD when the FIFO is non-empty (pop).
- LOAD computes clipped bounds: DRAW if the region is non-empty, else IDLE.
- DRAW to IDLE after the last pixel is accepted.
REQ-011 Clipping: X1 and Y1 SHALL be clamped to X_MAX and Y_MAX. A region with X0>X1, Y0>Y1, X0>X_MAX or Y0>Y_MAX (after clamp) SHALL emit zero pixels.
REQ-012 DRAW SHALL emit pixels row-major (x increments, then y), holding FB_X, FB_Y, FB_COLOR and FB_WE stable until FB_READY=1.
- Transfer = FB_WE & FB_READY.
- With FB_READY held high, throughput SHALL be one pixel per cycle.
REQ-013 Coordinate counters SHALL be X_W+1 and Y_W+1 bits wide internally so that X_MAX = 2^X_W-1 does not wrap.
REQ-014 Latency SHALL be: CMD write at edge N -> first FB_WE=1 no later than edge N+3 when the engine is idle.
REQ-015 A simultaneous push and pop SHALL both take effect. The full condition SHALL be evaluated before the pop.
REQ-016 BUSY SHALL be 1 whenever state is not IDLE or the FIFO is non-empty.
REQ-017 FB_WE SHALL be 0 outside DRAW.

Reset
REQ-018 RESETB=0 SHALL immediately clear all registers, the FIFO, the flags and the FSM.
- FSM returns to IDLE.
- DATA_OUT=0, FB_WE=0, FB_X=0, FB_Y=0, FB_COLOR=0, BUSY=0.
- An in-progress draw SHALL be aborted with no further pixels.
REQ-019 Release SHALL be clean: the first access honoured is in the first full cycle with RESETB=1.

Structure
REQ-020 Package gpu_pkg SHALL hold the register addresses, opcodes and STATUS bit indices.
REQ-021 The FIFO SHALL be sub-module gpu_cmd_fifo, parametrised by entry width and depth, with push, pop, full, empty and count.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- PLOT: COLOR=5, X0=3, Y0=4, CMD=0x00 -> exactly one transfer (3,4,5) within 3 cycles; BUSY returns to 0.
- FILL with FB_READY toggling every other cycle: X0=2..X1=4, Y0=1..Y1=2 -> 6 transfers in order (2,1),(3,1),(4,1),(2,2),(3,2),(4,2), with outputs stable while stalled.
- Overflow: FB_READY=0, 5 CMD writes with FIFO_DEPTH=4 -> STATUS bit1=1, bit3=1, FIFO_COUNT=4; writing CMD=0xFF clears bit3.
- Clip and bad op: FILL X0=158, X1=200, Y0=Y1=119 -> 2 pixels (158,119),(159,119); FILL X0=10, X1=5 -> 0 pixels; CMD=0x07 -> 0 pixels, STATUS bit4=1.
- Reset mid-FILL: assert RESETB=0 after 3 pixels of a 10x10 FILL -> FB_WE=0 immediately; after release STATUS=0x04 and no further pixels.
